// File: rtl/sgmii_phy_init_ctrl.sv
// SGMII transceiver bring-up controller.
// Sequences PLL lock, TX/RX reset, reset-done and comma alignment, and
// monitors the link once up. Failures restart the sequence from RESET
// and are tallied in a saturating retry counter.
module sgmii_phy_init_ctrl #(
    parameter int LOCK_TIMEOUT = 1250000,
    parameter int RESET_CYCLES = 16,
    parameter int SYNC_COMMAS  = 4,
    parameter int ERR_THRESH   = 8
) (
    input  logic       clk_125,
    input  logic       mgt_reset,
    input  logic       sgmii_pll_locked,
    input  logic       sgmii_resetdone,
    input  logic       sgmii_rxiscomma,
    input  logic       sgmii_rxnotintable,
    input  logic       sgmii_rxdisperr,
    input  logic [2:0] sgmii_rxbufstatus,
    input  logic       sgmii_elecidle,
    output logic       sgmii_txreset,
    output logic       sgmii_rxreset,
    output logic       sgmii_encommaalign,
    output logic       link_up,
    output logic [2:0] state,
    output logic [7:0] retry_count
);

    localparam int CCW = ($clog2(SYNC_COMMAS + 1) > 3) ? $clog2(SYNC_COMMAS + 1) : 3;
    localparam int ECW = ($clog2(ERR_THRESH + 1) > 3) ? $clog2(ERR_THRESH + 1) : 3;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_ASSERT_RST = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_ALIGN      = 3'd4,
        ST_LINK_UP    = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             lock_m;
    logic             lock_s;
    logic             idle_m;
    logic             idle_s;
    logic [23:0]      timer_q;
    logic [CCW-1:0]   comma_cnt_q;
    logic [CCW-1:0]   comma_cnt_d;
    logic [ECW-1:0]   err_cnt_q;
    logic [ECW-1:0]   err_cnt_d;
    logic             fail;
    logic             rx_err;
    logic             clean_comma;
    logic             timed_out;
    logic             unused_bufstatus;

    // Only the over/underflow flag of the elastic buffer status matters here.
    assign unused_bufstatus = ^sgmii_rxbufstatus[1:0];

    assign state = state_q;

    // Two-flop synchronizers for the inputs that are asynchronous to clk_125.
    always_ff @(posedge clk_125 or posedge mgt_reset) begin
        if (mgt_reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            idle_m <= 1'b0;
            idle_s <= 1'b0;
        end else begin
            lock_m <= sgmii_pll_locked;
            lock_s <= lock_m;
            idle_m <= sgmii_elecidle;
            idle_s <= idle_m;
        end
    end

    // Next-state, failure detection and counter updates.
    always_comb begin
        rx_err      = sgmii_rxnotintable | sgmii_rxdisperr;
        clean_comma = sgmii_rxiscomma & ~rx_err;
        timed_out   = (timer_q == 24'(LOCK_TIMEOUT - 1));
        state_d     = state_q;
        fail        = 1'b0;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)
                    state_d = ST_ASSERT_RST;
                else if (timed_out)
                    fail = 1'b1;
            end
            ST_ASSERT_RST: begin
                if (!lock_s)
                    fail = 1'b1;
                else if (timer_q == 24'(RESET_CYCLES - 1))
                    state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!lock_s)
                    fail = 1'b1;
                else if (sgmii_resetdone)
                    state_d = ST_ALIGN;
                else if (timed_out)
                    fail = 1'b1;
            end
            ST_ALIGN: begin
                if (rx_err || idle_s)
                    comma_cnt_d = '0;
                else if (clean_comma)
                    comma_cnt_d = comma_cnt_q + CCW'(1);

                if (!lock_s)
                    fail = 1'b1;
                else if (comma_cnt_d == CCW'(SYNC_COMMAS))
                    state_d = ST_LINK_UP;
                else if (timed_out)
                    fail = 1'b1;
            end
            ST_LINK_UP: begin
                if (rx_err)
                    err_cnt_d = err_cnt_q + ECW'(1);
                else
                    err_cnt_d = '0;

                if (!lock_s)
                    fail = 1'b1;
                else if (sgmii_rxbufstatus[2])
                    fail = 1'b1;
                else if (err_cnt_d == ECW'(ERR_THRESH))
                    state_d = ST_ALIGN;
                else if (idle_s)
                    state_d = ST_ALIGN;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (fail)
            state_d = ST_RESET;

        // Counters restart on every state change, which covers each entry to ALIGN.
        if (state_d != state_q) begin
            comma_cnt_d = '0;
            err_cnt_d   = '0;
        end
    end

    // State, timer, counters and registered outputs (outputs decoded from the next state).
    always_ff @(posedge clk_125 or posedge mgt_reset) begin
        if (mgt_reset) begin
            state_q            <= ST_RESET;
            timer_q            <= '0;
            comma_cnt_q        <= '0;
            err_cnt_q          <= '0;
            retry_count        <= '0;
            sgmii_txreset      <= 1'b1;
            sgmii_rxreset      <= 1'b1;
            sgmii_encommaalign <= 1'b0;
            link_up            <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= (state_d != state_q) ? '0 : timer_q + 24'd1;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            if (fail && (retry_count != '1))
                retry_count <= retry_count + 8'd1;
            sgmii_txreset      <= (state_d inside {ST_RESET, ST_WAIT_LOCK, ST_ASSERT_RST});
            sgmii_rxreset      <= (state_d inside {ST_RESET, ST_WAIT_LOCK, ST_ASSERT_RST});
            sgmii_encommaalign <= (state_d == ST_ALIGN);
            link_up            <= (state_d == ST_LINK_UP);
        end
    end

endmodule
